// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz) and small decode helpers,
// used by the sync generator and by the pixel generator.
package vga_timing_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 16;
  localparam int H_SYNC_DEF    = 96;
  localparam int H_BACK_DEF    = 48;
  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;
  localparam int CLK_DIV_DEF   = 4;

  localparam int H_TOTAL_DEF = H_DISPLAY_DEF + H_FRONT_DEF + H_SYNC_DEF + H_BACK_DEF;
  localparam int V_TOTAL_DEF = V_DISPLAY_DEF + V_FRONT_DEF + V_SYNC_DEF + V_BACK_DEF;

  // Counter width of the x/y position ports.
  localparam int CNT_W = 10;

  typedef logic [CNT_W-1:0] cnt_t;

  // True when pos lies in the inclusive window [lo, hi].
  function automatic logic in_window(input cnt_t pos, input cnt_t lo, input cnt_t hi);
    return (pos >= lo) && (pos <= hi);
  endfunction

  // Next value of a wrapping counter that advances only when enabled.
  function automatic cnt_t cnt_next(input cnt_t cur, input cnt_t last, input logic en);
    cnt_t nxt;
    nxt = cur;
    if (en) begin
      if (cur == last) nxt = '0;
      else             nxt = cur + 1'b1;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/pixel_tick_div.sv
// Free-running modulo-CLK_DIV divider; p_tick marks the last clk of each
// pixel period, so counters advancing on it hold for CLK_DIV clks.
module pixel_tick_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  output logic p_tick
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] div_q;
  logic [DIV_W-1:0] div_d;

  always_comb begin
    div_d = div_q + 1'b1;
    if (div_q == DIV_LAST) div_d = '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) div_q <= '0;
    else       div_q <= div_d;
  end

  assign p_tick = (div_q == DIV_LAST);

endmodule

// File: rtl/vga_sync.sv
// VGA sync generator: pixel/line counters, registered active-low syncs
// aligned with x/y, visible-area decode and an end-of-frame pulse.
module vga_sync
  import vga_timing_pkg::*;
#(
  parameter int H_DISPLAY = H_DISPLAY_DEF,
  parameter int H_FRONT   = H_FRONT_DEF,
  parameter int H_SYNC    = H_SYNC_DEF,
  parameter int H_BACK    = H_BACK_DEF,
  parameter int V_DISPLAY = V_DISPLAY_DEF,
  parameter int V_FRONT   = V_FRONT_DEF,
  parameter int V_SYNC    = V_SYNC_DEF,
  parameter int V_BACK    = V_BACK_DEF,
  parameter int CLK_DIV   = CLK_DIV_DEF
) (
  input  logic             clk,
  input  logic             reset,
  output logic             hsync,
  output logic             vsync,
  output logic             video_on,
  output logic             p_tick,
  output logic [CNT_W-1:0] x,
  output logic [CNT_W-1:0] y,
  output logic             frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam cnt_t H_LAST    = CNT_W'(H_TOTAL - 1);
  localparam cnt_t V_LAST    = CNT_W'(V_TOTAL - 1);
  localparam cnt_t H_VIS     = CNT_W'(H_DISPLAY);
  localparam cnt_t V_VIS     = CNT_W'(V_DISPLAY);
  localparam cnt_t H_SYNC_LO = CNT_W'(H_DISPLAY + H_FRONT);
  localparam cnt_t H_SYNC_HI = CNT_W'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam cnt_t V_SYNC_LO = CNT_W'(V_DISPLAY + V_FRONT);
  localparam cnt_t V_SYNC_HI = CNT_W'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic tick;
  logic line_end;

  cnt_t x_q, x_d;
  cnt_t y_q, y_d;
  logic hsync_q, hsync_d;
  logic vsync_q, vsync_d;

  pixel_tick_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk    (clk),
    .reset  (reset),
    .p_tick (tick)
  );

  assign line_end = tick && (x_q == H_LAST);

  // Syncs decode the next counts so the registered pins change on the same
  // edge as x/y and never see a combinational glitch.
  always_comb begin
    x_d     = cnt_next(x_q, H_LAST, tick);
    y_d     = cnt_next(y_q, V_LAST, line_end);
    hsync_d = ~in_window(x_d, H_SYNC_LO, H_SYNC_HI);
    vsync_d = ~in_window(y_d, V_SYNC_LO, V_SYNC_HI);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q     <= '0;
      y_q     <= '0;
      hsync_q <= 1'b1;
      vsync_q <= 1'b1;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
    end
  end

  assign x          = x_q;
  assign y          = y_q;
  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign p_tick     = tick;
  assign video_on   = (x_q < H_VIS) && (y_q < V_VIS);
  assign frame_tick = line_end && (y_q == V_LAST);

endmodule

// File: tb/tb_vga_sync.sv
// Bench for vga_sync: a default-timing instance and a small-timing instance
// compared every clk against a pixel-count model, with random async resets.
module tb_vga_sync;

  localparam int S_CD = 2;
  localparam int S_HD = 8;
  localparam int S_HF = 2;
  localparam int S_HS = 3;
  localparam int S_HB = 2;
  localparam int S_VD = 6;
  localparam int S_VF = 2;
  localparam int S_VS = 2;
  localparam int S_VB = 2;

  typedef struct packed {
    logic [31:0] x;
    logic [31:0] y;
    logic        hs;
    logic        vs;
    logic        von;
    logic        pt;
    logic        ft;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;

  logic       d_hs, d_vs, d_von, d_pt, d_ft;
  logic [9:0] d_x, d_y;
  logic       s_hs, s_vs, s_von, s_pt, s_ft;
  logic [9:0] s_x, s_y;

  int n = 0;
  int n_assert = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  vga_sync dut_def (
    .clk        (clk),
    .reset      (reset),
    .hsync      (d_hs),
    .vsync      (d_vs),
    .video_on   (d_von),
    .p_tick     (d_pt),
    .x          (d_x),
    .y          (d_y),
    .frame_tick (d_ft)
  );

  vga_sync #(
    .H_DISPLAY (S_HD), .H_FRONT (S_HF), .H_SYNC (S_HS), .H_BACK (S_HB),
    .V_DISPLAY (S_VD), .V_FRONT (S_VF), .V_SYNC (S_VS), .V_BACK (S_VB),
    .CLK_DIV   (S_CD)
  ) dut_sml (
    .clk        (clk),
    .reset      (reset),
    .hsync      (s_hs),
    .vsync      (s_vs),
    .video_on   (s_von),
    .p_tick     (s_pt),
    .x          (s_x),
    .y          (s_y),
    .frame_tick (s_ft)
  );

  // Clk edges since reset was last released.
  always @(posedge clk or posedge reset) begin
    if (reset) n <= 0;
    else       n <= n + 1;
  end

  // Expected outputs after n clks: n/cd whole pixels have elapsed.
  function automatic exp_t model(input int cnt, input int cd,
                                 input int hd, input int hf, input int hs, input int hb,
                                 input int vd, input int vf, input int vs, input int vb);
    exp_t e;
    int ht, vt, p, px, py;
    ht = hd + hf + hs + hb;
    vt = vd + vf + vs + vb;
    p  = cnt / cd;
    px = p % ht;
    py = (p / ht) % vt;
    e.x   = 32'(px);
    e.y   = 32'(py);
    e.pt  = ((cnt % cd) == cd - 1);
    e.ft  = e.pt && (px == ht - 1) && (py == vt - 1);
    e.von = (px < hd) && (py < vd);
    e.hs  = !((px >= hd + hf) && (px < hd + hf + hs));
    e.vs  = !((py >= vd + vf) && (py < vd + vf + vs));
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    assert (act === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic check_both(input string tag);
    exp_t e;
    e = model(n, 4, 640, 16, 96, 48, 480, 10, 2, 33);
    chk({tag, " def.x"},          32'(d_x),   e.x);
    chk({tag, " def.y"},          32'(d_y),   e.y);
    chk({tag, " def.hsync"},      32'(d_hs),  32'(e.hs));
    chk({tag, " def.vsync"},      32'(d_vs),  32'(e.vs));
    chk({tag, " def.video_on"},   32'(d_von), 32'(e.von));
    chk({tag, " def.p_tick"},     32'(d_pt),  32'(e.pt));
    chk({tag, " def.frame_tick"}, 32'(d_ft),  32'(e.ft));
    e = model(n, S_CD, S_HD, S_HF, S_HS, S_HB, S_VD, S_VF, S_VS, S_VB);
    chk({tag, " sml.x"},          32'(s_x),   e.x);
    chk({tag, " sml.y"},          32'(s_y),   e.y);
    chk({tag, " sml.hsync"},      32'(s_hs),  32'(e.hs));
    chk({tag, " sml.vsync"},      32'(s_vs),  32'(e.vs));
    chk({tag, " sml.video_on"},   32'(s_von), 32'(e.von));
    chk({tag, " sml.p_tick"},     32'(s_pt),  32'(e.pt));
    chk({tag, " sml.frame_tick"}, 32'(s_ft),  32'(e.ft));
  endtask

  task automatic run(input string tag, input int clks);
    repeat (clks) begin
      @(negedge clk);
      check_both(tag);
    end
  endtask

  initial begin
    int hs_low, hs_first, von_low;
    int ft_cnt, ft_x, ft_y, pt_cnt, vs_low;
    bit found;

    // Reset state
    repeat (3) @(negedge clk);
    check_both("in_reset");
    chk("in_reset.video_on", 32'(d_von), 32'd1);
    chk("in_reset.hsync", 32'(d_hs), 32'd1);

    // First pixel periods after release
    reset = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check_both("start");
      chk("start.p_tick", 32'(d_pt), 32'((k == 3) || (k == 7)));
      chk("start.x", 32'(d_x), 32'(k / 4));
    end

    // One full default line, plus small-instance frame statistics
    hs_low = 0; hs_first = -1; von_low = 0;
    ft_cnt = 0; ft_x = -1; ft_y = -1; pt_cnt = 0; vs_low = 0;
    repeat (3200) begin
      @(negedge clk);
      check_both("line");
      if (n < 3200) begin
        if (!d_hs) begin
          hs_low++;
          if (hs_first < 0) hs_first = int'(d_x);
        end
        if (!d_von) von_low++;
      end
      if (n >= 360 && n < 720) begin
        if (s_pt) pt_cnt++;
        if (!s_vs) vs_low++;
        if (s_ft) begin
          ft_cnt++;
          ft_x = int'(s_x);
          ft_y = int'(s_y);
        end
      end
      if (n == 720) begin
        chk("wrap.x", 32'(s_x), 32'd0);
        chk("wrap.y", 32'(s_y), 32'd0);
        chk("wrap.video_on", 32'(s_von), 32'd1);
        chk("wrap.hsync", 32'(s_hs), 32'd1);
        chk("wrap.vsync", 32'(s_vs), 32'd1);
      end
    end
    chk("line.hsync_low_clks", 32'(hs_low), 32'd384);
    chk("line.hsync_first_x", 32'(hs_first), 32'd656);
    chk("line.video_off_clks", 32'(von_low), 32'd640);
    chk("frame.pixels", 32'(pt_cnt), 32'(15 * 12));
    chk("frame.vsync_low_clks", 32'(vs_low), 32'(S_VS * 15 * S_CD));
    chk("frame.frame_ticks", 32'(ft_cnt), 32'd1);
    chk("frame.tick_x", 32'(ft_x), 32'd14);
    chk("frame.tick_y", 32'(ft_y), 32'd11);

    // Asynchronous reset in mid-frame of the small instance
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      check_both("seek");
      if (s_x == 10'd10 && s_y == 10'd7) found = 1'b1;
    end
    chk("seek.found", 32'(found), 32'd1);
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    chk("async_rst.x", 32'(s_x), 32'd0);
    chk("async_rst.y", 32'(s_y), 32'd0);
    chk("async_rst.hsync", 32'(s_hs), 32'd1);
    chk("async_rst.vsync", 32'(s_vs), 32'd1);
    check_both("async_rst");
    run("rst_hold", 1);
    reset = 1'b0;

    // Random run lengths interrupted by random mid-cycle resets
    for (int it = 0; it < 25; it++) begin
      run("rand_run", int'($urandom_range(1, 500)));
      @(posedge clk);
      #($urandom_range(1, 8)) reset = 1'b1;
      #1;
      check_both("rand_rst");
      run("rand_hold", int'($urandom_range(1, 3)));
      reset = 1'b0;
    end
    run("tail", 50);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_sync.md
VGA_SYNC -- requirements
Module: vga_sync

Interface
REQ-001 The block SHALL expose parameter H_DISPLAY, default 640, visible pixels per line.
REQ-002 The block SHALL expose parameter H_FRONT, default 16, horizontal front porch in pixels.
REQ-003 The block SHALL expose parameter H_SYNC, default 96, horizontal sync width in pixels.
REQ-004 The block SHALL expose parameter H_BACK, default 48, horizontal back porch in pixels.
REQ-005 The block SHALL expose parameter V_DISPLAY, default 480, visible lines per frame.
REQ-006 The block SHALL expose parameter V_FRONT, default 10, vertical front porch in lines.
REQ-007 The block SHALL expose parameter V_SYNC, default 2, vertical sync width in lines.
REQ-008 The block SHALL expose parameter V_BACK, default 33, vertical back porch in lines.
REQ-009 The block SHALL expose parameter CLK_DIV, default 4, clk cycles per pixel.
REQ-010 The block SHALL have port clk, input, 1, system clock (100 MHz).
REQ-011 The block SHALL have port reset, input, 1, reset, asynchronous, active-high.
REQ-012 The block SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-013 The block SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-014 The block SHALL have port video_on, output, 1, high while (x, y) is in the visible area.
REQ-015 The block SHALL have port p_tick, output, 1, one-clk pulse per pixel period.
REQ-016 The block SHALL have port x, output, 10, current pixel column.
REQ-017 The block SHALL have port y, output, 10, current line.
REQ-018 The block SHALL have port frame_tick, output, 1, one-clk pulse on the last pixel of a frame.

Function
REQ-019 Define H_TOTAL = sum of the H parameters (800) and V_TOTAL = sum of the V parameters (525).
REQ-020 A modulo-CLK_DIV divider SHALL count every clk; p_tick SHALL be high exactly when the divider equals CLK_DIV-1.
REQ-021 On a clk edge with p_tick high, x SHALL increment; at x = H_TOTAL-1 it SHALL wrap to 0.
REQ-022 y SHALL increment only on the edge where x wraps; y SHALL wrap from V_TOTAL-1 to 0 on that same edge.
REQ-023 x and y SHALL hold their value on every clk where p_tick is low.
REQ-024 video_on SHALL equal (x < H_DISPLAY) && (y < V_DISPLAY), decoded from the current counter registers in the same cycle.
REQ-025 hsync SHALL be 0 iff H_DISPLAY+H_FRONT <= x <= H_DISPLAY+H_FRONT+H_SYNC-1 (656..751), else 1.
REQ-026 vsync SHALL be 0 iff V_DISPLAY+V_FRONT <= y <= V_DISPLAY+V_FRONT+V_SYNC-1 (490..491), else 1.
REQ-027 hsync and vsync SHALL be registered and cycle-aligned with x/y, with no combinational glitch at the pins; they are computed from next-count values.
REQ-028 frame_tick SHALL be high for exactly one clk, when p_tick = 1, x = H_TOTAL-1 and y = V_TOTAL-1.
REQ-029 Pixel consumers sampling (x, y) in any clk SHALL see a stable value for CLK_DIV clks, except for the first clk after reset.

Reset
REQ-030 While reset is high: divider = 0, x = 0, y = 0, hsync = 1, vsync = 1, p_tick = 0, frame_tick = 0; video_on = 1 (decoded from 0,0).
REQ-031 Reset assertion at any point mid-line or mid-frame SHALL take effect immediately, with no completion of the current line.
REQ-032 After reset is released, the first p_tick SHALL occur on the CLK_DIV-th clk edge (divider reaching 3).

Structure
REQ-033 A shared package vga_timing_pkg SHALL hold the default H/V timing constants and the derived H_TOTAL/V_TOTAL, for use by this block and the pixel generator.
REQ-034 The divider SHALL be a sub-module named pixel_tick_div (parameter CLK_DIV, outputs p_tick); the counters and sync decode stay in vga_sync.

Verification
REQ-035 Release reset, run 8 clks -> p_tick high on clks 4 and 8 only; x = 0 then 1 then 2 at the matching boundaries.
REQ-036 Run one full line -> hsync low for exactly 96*4 = 384 clks starting at x = 656; video_on low from x = 640 through 799.
REQ-037 Run one full frame -> 420,000 pixels (800*525), vsync low for exactly 2 lines (y = 490, 491), and exactly one frame_tick at x = 799, y = 524.
REQ-038 At x = 799, y = 524 with p_tick -> next state x = 0, y = 0, video_on = 1, hsync = 1, vsync = 1.
REQ-039 Assert reset at x = 700, y = 300 -> x = 0, y = 0, hsync = 1, vsync = 1 asynchronously, before the next clk edge.
REQ-040 Override parameters with CLK_DIV = 2 and H_DISPLAY = 8 (small totals) -> wrap points and sync windows track the parameters exactly.
